// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame streamer: default resolution,
// FSM state encoding and SSD1306 addressing command bytes.
package oled_pkg;

  localparam int unsigned DEF_H_PIXELS = 128;
  localparam int unsigned DEF_V_PIXELS = 64;

  // SSD1306 page/column addressing commands
  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_SEND = 3'd4
  } state_t;

endpackage : oled_pkg

// File: rtl/oled_frame_streamer.sv
// Streams one framebuffer frame to an SSD1306-style byte serializer, page by
// page and column by column, bit-reversing each column byte so LSB = top row.
// Optional macro OLED_STREAMER_PAGE_CMD_EN: emit page/column address commands
// (0xB0|page, 0x00, 0x10) before every page.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int unsigned H_PIXELS = DEF_H_PIXELS,
  parameter int unsigned V_PIXELS = DEF_V_PIXELS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       fb_re,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic       fb_rmode,
  input  logic [7:0] fb_dout,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned PAGES     = V_PIXELS / 8;
  localparam logic [7:0]  LAST_COL  = 8'(H_PIXELS - 1);
  localparam logic [7:0]  LAST_PAGE = 8'(PAGES - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] col_q, col_d;
  logic       busy_d, frame_done_d, fb_re_d, tx_valid_d, tx_dc_d;
  logic [7:0] fb_xpos_d, fb_ypos_d, tx_data_d;
  logic [7:0] fb_rev;
  logic       hs;
`ifdef OLED_STREAMER_PAGE_CMD_EN
  logic [1:0] cmd_idx_q, cmd_idx_d;
`endif

  assign fb_rmode = 1'b1;
  assign hs       = tx_valid & tx_ready;

  // Column byte bit reversal: framebuffer bit 7 is the top row
  always_comb begin
    fb_rev = 8'h00;
    for (int i = 0; i < 8; i++) fb_rev[i] = fb_dout[7-i];
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      page_q     <= 8'd0;
      col_q      <= 8'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      fb_re      <= 1'b0;
      fb_xpos    <= 8'd0;
      fb_ypos    <= 8'd0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      tx_dc      <= 1'b0;
`ifdef OLED_STREAMER_PAGE_CMD_EN
      cmd_idx_q  <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      col_q      <= col_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      fb_re      <= fb_re_d;
      fb_xpos    <= fb_xpos_d;
      fb_ypos    <= fb_ypos_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      tx_dc      <= tx_dc_d;
`ifdef OLED_STREAMER_PAGE_CMD_EN
      cmd_idx_q  <= cmd_idx_d;
`endif
    end
  end

  // Next-state, counter and output computation
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    col_d        = col_q;
    busy_d       = busy;
    frame_done_d = 1'b0;
    fb_re_d      = 1'b0;
    fb_xpos_d    = fb_xpos;
    fb_ypos_d    = fb_ypos;
    tx_valid_d   = tx_valid;
    tx_data_d    = tx_data;
    tx_dc_d      = tx_dc;
`ifdef OLED_STREAMER_PAGE_CMD_EN
    cmd_idx_d    = cmd_idx_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          page_d = 8'd0;
          col_d  = 8'd0;
`ifdef OLED_STREAMER_PAGE_CMD_EN
          state_d = ST_CMD;
`else
          state_d = ST_REQ;
`endif
        end
      end
`ifdef OLED_STREAMER_PAGE_CMD_EN
      ST_CMD: begin
        if (hs) begin
          if (cmd_idx_q == 2'd2) begin
            tx_valid_d = 1'b0;
            state_d    = ST_REQ;
          end else begin
            cmd_idx_d = cmd_idx_q + 2'd1;
            tx_data_d = (cmd_idx_q == 2'd0) ? CMD_COL_LO : CMD_COL_HI;
          end
        end
      end
`endif
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tx_valid_d = 1'b1;
        tx_dc_d    = 1'b1;
        tx_data_d  = fb_rev;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          if (col_q == LAST_COL) begin
            col_d = 8'd0;
            if (page_q == LAST_PAGE) begin
              page_d       = 8'd0;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              page_d = page_q + 8'd1;
`ifdef OLED_STREAMER_PAGE_CMD_EN
              state_d = ST_CMD;
`else
              state_d = ST_REQ;
`endif
            end
          end else begin
            col_d   = col_q + 8'd1;
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering REQ issues the single-cycle framebuffer read
    if (state_d == ST_REQ) begin
      fb_re_d   = 1'b1;
      fb_xpos_d = col_d;
      fb_ypos_d = {page_d[4:0], 3'b000};
    end

`ifdef OLED_STREAMER_PAGE_CMD_EN
    // Entering CMD presents the page-select byte
    if (state_d == ST_CMD && state_q != ST_CMD) begin
      cmd_idx_d  = 2'd0;
      tx_valid_d = 1'b1;
      tx_dc_d    = 1'b0;
      tx_data_d  = CMD_PAGE_BASE | page_d;
    end
`endif
  end

endmodule : oled_frame_streamer
